// File: rtl/ser_pkg.sv
// Shared definitions for the byte serializer.
//   state_t   : serializer FSM states (IDLE, SHIFT)
//   DEF_WIDTH : default bits per word
//   DEF_DIV   : default clock cycles per bit period
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 1;

endpackage

// File: rtl/byte_serializer_bit_pacer.sv
// Bit-period pacer: counts DIV clock cycles per serial bit and flags the
// last cycle of each period.
// Ports:
//   clk  : rising-edge clock
//   res  : synchronous active-low reset
//   en   : count while high (serializer is shifting)
//   load : a new word enters the shifter; restarts the bit period
//   tick : last cycle of the current bit period (en must be high)
module bit_pacer
  import ser_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic load,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // With DIV=1 LAST is 0 and the counter never leaves 0.
  always_ff @(posedge clk) begin
    if (!res || load) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick = en & (div_cnt == LAST);

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that
// consecutive words stream without a gap.
// Ports:
//   clk         : rising-edge clock
//   res         : synchronous active-low reset
//   din         : parallel word in
//   din_valid   : din is valid
//   din_ready   : a word can be accepted this cycle
//   sout        : serial data out
//   sout_valid  : sout carries a live bit
//   bit_tick    : last cycle of each bit period (downstream shift enable)
//   frame_start : high for the whole first bit period of a word
//   frame_end   : high for the whole last bit period of a word
//   busy        : shifting or holding register full
module byte_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b0,
  parameter int DIV       = DEF_DIV
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             bit_tick,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_n;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;

  logic xfer, tick, last_tick, shifting;
  logic load_din, load_hold, hold_set, hold_clr, shift;

  assign shifting  = (state == SHIFT);
  assign din_ready = res & ~hold_full;
  assign xfer      = din_valid & din_ready;
  assign last_tick = tick & (bit_cnt == LAST_BIT);

  bit_pacer #(
    .DIV (DIV)
  ) u_pacer (
    .clk  (clk),
    .res  (res),
    .en   (shifting),
    .load (load_din | load_hold),
    .tick (tick)
  );

  always_comb begin
    state_n   = state;
    load_din  = 1'b0;
    load_hold = 1'b0;
    hold_set  = 1'b0;
    hold_clr  = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          load_din = 1'b1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (last_tick) begin
          // din_ready is low whenever hold is full, so at most one of
          // these two reload sources can apply.
          if (hold_full) begin
            load_hold = 1'b1;
            hold_clr  = 1'b1;
          end else if (xfer) begin
            load_din = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          shift    = tick;
          hold_set = xfer;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk) begin
    if (!res) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      state <= state_n;
      if (hold_set) begin
        hold_full <= 1'b1;
      end else if (hold_clr) begin
        hold_full <= 1'b0;
      end
      if (load_din || load_hold) begin
        bit_cnt <= '0;
      end else if (shift) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Data path: contents only matter while the matching control flag is set,
  // so these registers carry no reset.
  always_ff @(posedge clk) begin
    if (hold_set) begin
      hold_data <= din;
    end
    if (load_din) begin
      shreg <= din;
    end else if (load_hold) begin
      shreg <= hold_data;
    end else if (shift) begin
      shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
    end
  end

  assign sout        = shifting & (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
  assign sout_valid  = shifting;
  assign bit_tick    = tick;
  assign frame_start = shifting & (bit_cnt == '0);
  assign frame_end   = shifting & (bit_cnt == LAST_BIT);
  assign busy        = shifting | hold_full;

endmodule
